// File: rtl/sram_pkg.sv
// Shared SRAM geometry for the 2 KB 1RW1R leaf macro model.
// Wrappers and banks import this so they agree on word width, depth and mask lanes.
package sram_pkg;

   localparam int unsigned SRAM_DATA_WIDTH = 32;
   localparam int unsigned SRAM_ADDR_WIDTH = 9;
   localparam int unsigned SRAM_NUM_WMASKS = 4;
   localparam int unsigned SRAM_LANE_WIDTH = SRAM_DATA_WIDTH / SRAM_NUM_WMASKS;
   localparam int unsigned SRAM_DEPTH      = 2 ** SRAM_ADDR_WIDTH;

   typedef logic [SRAM_DATA_WIDTH-1:0] sram_word_t;

endpackage

// File: rtl/sram_byte_lane.sv
// One byte lane of the 1RW1R SRAM: LANE_WIDTH x 2**ADDR_WIDTH storage with a lane
// write enable on port 0 and a registered read output per port.
// Ports:
//   clk            rising-edge clock
//   clr            synchronous clear of both read registers
//   we             write din to mem[addr0]
//   rd0, rd1       load the port 0 / port 1 read register
//   addr0, addr1   port 0 / port 1 word address
//   din            lane write data
//   dout0, dout1   registered lane read data
module sram_byte_lane #(
   parameter int unsigned LANE_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 9,
   parameter int unsigned WORD_WIDTH = 32,
   parameter int unsigned LANE_INDEX = 0,
   parameter string       INIT_FILE  = ""
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  we,
   input  logic                  rd0,
   input  logic                  rd1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [LANE_WIDTH-1:0] din,
   output logic [LANE_WIDTH-1:0] dout0,
   output logic [LANE_WIDTH-1:0] dout1
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [LANE_WIDTH-1:0] mem_q [DEPTH];
   logic [LANE_WIDTH-1:0] dout0_q;
   logic [LANE_WIDTH-1:0] dout1_q;

   // Reads sample mem_q before this edge's write lands, giving read-before-write
   // on an address collision between the two ports.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr0] <= din;
      end
      if (clr) begin
         dout0_q <= '0;
         dout1_q <= '0;
      end else begin
         if (rd0) dout0_q <= mem_q[addr0];
         if (rd1) dout1_q <= mem_q[addr1];
      end
   end

   assign dout0 = dout0_q;
   assign dout1 = dout1_q;

endmodule

// File: rtl/sram_1rw1r_32x512_model.sv
// Behavioural model of the SKY130 2 KB dual-port SRAM macro (512 x 32).
// Port 0 is read/write with a per-byte write mask, port 1 is read-only.
// Both read outputs are registered (1-cycle latency); no input-to-output path.
// Ports:
//   clk            rising-edge clock for both ports
//   rst            synchronous active-high reset; zeroes dout0/dout1, blocks accesses
//   vccd1, vssd1   power pins (USE_POWER_PINS only), no functional effect
//   csb0, web0     port 0 chip select / write enable, both active low
//   wmask0         port 0 byte write mask, bit i enables lane i
//   addr0, din0    port 0 word address / write data
//   dout0          port 0 registered read data
//   csb1, addr1    port 1 chip select (active low) / word address
//   dout1          port 1 registered read data
module sram_1rw1r_32x512_model
   import sram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = SRAM_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = SRAM_ADDR_WIDTH,
   parameter int unsigned NUM_WMASKS = SRAM_NUM_WMASKS,
   parameter string       INIT_FILE  = ""
) (
`ifdef USE_POWER_PINS
   inout  wire                   vccd1,
   inout  wire                   vssd1,
`endif
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  csb0,
   input  logic                  web0,
   input  logic [NUM_WMASKS-1:0] wmask0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] din0,
   output logic [DATA_WIDTH-1:0] dout0,
   input  logic                  csb1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   output logic [DATA_WIDTH-1:0] dout1
);

   localparam int unsigned LANE_WIDTH = DATA_WIDTH / NUM_WMASKS;

   logic wr0;
   logic rd0;
   logic rd1;

   // Reset masks every access so nothing reaches the array while rst is high.
   always_comb begin
      wr0 = !rst && !csb0 && !web0;
      rd0 = !rst && !csb0 && web0;
      rd1 = !rst && !csb1;
   end

   for (genvar i = 0; i < int'(NUM_WMASKS); i++) begin : g_lane
      sram_byte_lane #(
         .LANE_WIDTH (LANE_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH),
         .WORD_WIDTH (DATA_WIDTH),
         .LANE_INDEX (i),
         .INIT_FILE  (INIT_FILE)
      ) u_lane (
         .clk   (clk),
         .clr   (rst),
         .we    (wr0 && wmask0[i]),
         .rd0   (rd0),
         .rd1   (rd1),
         .addr0 (addr0),
         .addr1 (addr1),
         .din   (din0[i*LANE_WIDTH +: LANE_WIDTH]),
         .dout0 (dout0[i*LANE_WIDTH +: LANE_WIDTH]),
         .dout1 (dout1[i*LANE_WIDTH +: LANE_WIDTH])
      );
   end

endmodule

// File: tb/tb_sram_1rw1r_32x512_model.sv
module tb_sram_1rw1r_32x512_model;

   logic        clk;
   logic        rst;
   logic        csb0;
   logic        web0;
   logic [3:0]  wmask0;
   logic [8:0]  addr0;
   logic [31:0] din0;
   logic [31:0] dout0;
   logic        csb1;
   logic [8:0]  addr1;
   logic [31:0] dout1;

   int checks = 0;
   int errors = 0;

   // Reference model: word array plus the read values each port should show.
   logic [31:0] mem_m [512];
   logic [31:0] exp0;
   logic [31:0] exp1;

   sram_1rw1r_32x512_model dut (
      .clk    (clk),
      .rst    (rst),
      .csb0   (csb0),
      .web0   (web0),
      .wmask0 (wmask0),
      .addr0  (addr0),
      .din0   (din0),
      .dout0  (dout0),
      .csb1   (csb1),
      .addr1  (addr1),
      .dout1  (dout1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_p0(input logic cs, input logic we, input logic [3:0] m,
                         input logic [8:0] a, input logic [31:0] d);
      csb0 = cs; web0 = we; wmask0 = m; addr0 = a; din0 = d;
   endtask

   task automatic set_p1(input logic cs, input logic [8:0] a);
      csb1 = cs; addr1 = a;
   endtask

   task automatic idle();
      set_p0(1'b1, 1'b1, 4'h0, 9'd0, 32'd0);
      set_p1(1'b1, 9'd0);
   endtask

   // Advance one edge: reads see the old array, then masked writes are applied.
   task automatic step();
      if (rst) begin
         exp0 = 32'd0;
         exp1 = 32'd0;
      end else begin
         if (!csb1) exp1 = mem_m[addr1];
         if (!csb0 && web0) exp0 = mem_m[addr0];
         if (!csb0 && !web0)
            for (int i = 0; i < 4; i++)
               if (wmask0[i]) mem_m[addr0][8*i +: 8] = din0[8*i +: 8];
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; idle(); step();
      rst = 1'b0; set_p0(1'b0, 1'b0, 4'hF, 9'd5, 32'h0F0F0F0F); step();
      rst = 1'b1; set_p0(1'b0, 1'b0, 4'hF, 9'd5, 32'hFFFFFFFF); set_p1(1'b0, 9'd5);
      for (int c = 0; c < 2; c++) begin
         step();
         checks++;
         if (dout0 !== 32'd0 || dout1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_out cycle %0d: dout0=%h dout1=%h, required 0/0", c, dout0, dout1);
         end
      end
      rst = 1'b0; set_p0(1'b0, 1'b1, 4'h0, 9'd5, 32'd0); set_p1(1'b0, 9'd5); step();
      checks++;
      if (dout0 !== 32'h0F0F0F0F || dout1 !== 32'h0F0F0F0F) begin
         errors++;
         $display("FAIL reset_no_write: dout0=%h dout1=%h, required 0f0f0f0f", dout0, dout1);
      end
      idle();
   endtask

   task automatic test_full_write_read();
      set_p0(1'b0, 1'b0, 4'hF, 9'h1A5, 32'hDEADBEEF); step();
      checks++;
      if (dout0 !== 32'h0F0F0F0F) begin
         errors++;
         $display("FAIL write_holds_dout0: dout0=%h, required 0f0f0f0f", dout0);
      end
      set_p0(1'b0, 1'b1, 4'h0, 9'h1A5, 32'd0); set_p1(1'b0, 9'h1A5); step();
      checks++;
      if (dout0 !== 32'hDEADBEEF || dout1 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL full_rw: dout0=%h dout1=%h, required deadbeef", dout0, dout1);
      end
      idle();
   endtask

   task automatic test_byte_mask();
      set_p0(1'b0, 1'b0, 4'hF, 9'd3, 32'h11223344); step();
      set_p0(1'b0, 1'b0, 4'h5, 9'd3, 32'hAABBCCDD); step();
      set_p0(1'b0, 1'b1, 4'h0, 9'd3, 32'd0); step();
      checks++;
      if (dout0 !== 32'h11BB33DD) begin
         errors++;
         $display("FAIL byte_mask: dout0=%h, required 11bb33dd", dout0);
      end
      set_p0(1'b0, 1'b0, 4'h0, 9'd3, 32'hFFFFFFFF); step();
      set_p0(1'b0, 1'b1, 4'h0, 9'd3, 32'd0); set_p1(1'b0, 9'd3); step();
      checks++;
      if (dout0 !== 32'h11BB33DD || dout1 !== 32'h11BB33DD) begin
         errors++;
         $display("FAIL zero_mask: dout0=%h dout1=%h, required 11bb33dd", dout0, dout1);
      end
      idle();
   endtask

   task automatic test_collision();
      set_p0(1'b0, 1'b0, 4'hF, 9'd7, 32'h00000001); step();
      set_p0(1'b0, 1'b0, 4'hF, 9'd7, 32'h00000002); set_p1(1'b0, 9'd7); step();
      checks++;
      if (dout1 !== 32'h00000001) begin
         errors++;
         $display("FAIL collision_old: dout1=%h, required 00000001", dout1);
      end
      idle(); set_p1(1'b0, 9'd7); step();
      checks++;
      if (dout1 !== 32'h00000002) begin
         errors++;
         $display("FAIL collision_new: dout1=%h, required 00000002", dout1);
      end
      idle();
   endtask

   task automatic test_deselect_hold();
      set_p0(1'b0, 1'b0, 4'hF, 9'd0, 32'hCAFEF00D); step();
      set_p0(1'b0, 1'b1, 4'h0, 9'd0, 32'd0); set_p1(1'b0, 9'd0); step();
      for (int c = 0; c < 3; c++) begin
         set_p0(1'b1, c[0], 4'hF, 9'(c + 7), 32'h55555555);
         set_p1(1'b1, 9'(c + 3));
         step();
         checks++;
         if (dout0 !== 32'hCAFEF00D || dout1 !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL deselect_hold cycle %0d: dout0=%h dout1=%h, required cafef00d",
                     c, dout0, dout1);
         end
      end
      idle();
   endtask

   task automatic test_extremes();
      set_p0(1'b0, 1'b0, 4'hF, 9'd0, 32'h00000000); step();
      set_p0(1'b0, 1'b0, 4'hF, 9'd511, 32'hFFFFFFFF); step();
      set_p0(1'b0, 1'b1, 4'h0, 9'd511, 32'd0); set_p1(1'b0, 9'd0); step();
      checks++;
      if (dout0 !== 32'hFFFFFFFF || dout1 !== 32'h00000000) begin
         errors++;
         $display("FAIL extremes: dout0=%h dout1=%h, required ffffffff/00000000", dout0, dout1);
      end
      idle();
   endtask

   task automatic test_random();
      // Fill the whole array so every random read has a defined value.
      for (int a = 0; a < 512; a++) begin
         set_p0(1'b0, 1'b0, 4'hF, 9'(a), $urandom);
         step();
      end
      for (int c = 0; c < 2000; c++) begin
         logic narrow;
         narrow = $urandom_range(0, 1) == 1;
         set_p0($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 4'($urandom),
                narrow ? 9'($urandom_range(0, 7)) : 9'($urandom), $urandom);
         set_p1($urandom_range(0, 3) == 0, narrow ? 9'($urandom_range(0, 7)) : 9'($urandom));
         rst = ($urandom_range(0, 99) == 0);
         step();
         checks++;
         if (dout0 !== exp0 || dout1 !== exp1) begin
            errors++;
            $display("FAIL random cycle %0d: dout0=%h dout1=%h, required %h/%h",
                     c, dout0, dout1, exp0, exp1);
         end
      end
      rst = 1'b0;
      idle();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      exp0 = 32'd0;
      exp1 = 32'd0;
      test_reset();
      test_full_write_read();
      test_byte_mask();
      test_collision();
      test_deselect_hold();
      test_extremes();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
